// File: rtl/sccb_bus_if.sv
// sccb_bus_if: command/response bus between the init sequencer (master) and sccb_bridge (slave).
interface sccb_bus_if;
    logic [2:0]  mcmd;
    logic [14:0] maddr;
    logic [7:0]  mdata;
    logic        scmdaccept;
    logic [1:0]  sresp;
    logic [7:0]  sdata;
    modport master (output mcmd, maddr, mdata, input scmdaccept, sresp, sdata);
    modport slave  (input mcmd, maddr, mdata, output scmdaccept, sresp, sdata);
endinterface

// File: rtl/sccb_init_seq.sv
// sccb_init_seq: walks a ROM register-init table into sccb_bridge, then serves one host register port.
module sccb_init_seq #(
    parameter int          AW         = 8,
    parameter int          DELAY_UNIT = 25000,
    parameter logic [23:0] TIMEOUT    = 24'hFFFFFF
) (
    input  logic          sccb_clk,
    input  logic          sccb_reset,
    input  logic          start,
    input  logic [6:0]    dev_id,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    sccb_bus_if.master    bus,
    output logic          busy,
    output logic          done,
    output logic          error,
    input  logic          host_req,
    input  logic          host_rd,
    input  logic [7:0]    host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_ack,
    output logic [7:0]    host_rdata
);
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_WAIT_ACC, S_WAIT_DONE, S_DELAY,
        S_NEXT, S_DONE, S_H_ISSUE, S_H_WAIT_ACC, S_H_WAIT_DONE, S_ERR
    } state_t;

    state_t        r_state, w_next;
    logic [AW-1:0] r_ptr;
    logic [15:0]   r_entry;
    logic          r_hrd, r_cap, r_ack;
    logic [31:0]   r_dly;
    logic [23:0]   r_to;
    logic [2:0]    r_mcmd;
    logic [14:0]   r_maddr;
    logic [7:0]    r_mdata, r_rdata;
    logic          w_wait, w_to;

    assign w_wait = r_state inside {S_WAIT_ACC, S_WAIT_DONE, S_H_WAIT_ACC, S_H_WAIT_DONE};
    assign w_to   = w_wait && (r_to == TIMEOUT - 24'd1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:        w_next = start ? S_FETCH : S_IDLE;
            S_FETCH:       w_next = S_DECODE;
            S_DECODE:      w_next = (tbl_data[15:8] == 8'hFF) ? S_DONE :
                                    (tbl_data[15:8] != 8'hFE) ? S_ISSUE :
                                    (tbl_data[7:0] == 8'h00)  ? S_NEXT : S_DELAY;
            S_ISSUE:       w_next = S_WAIT_ACC;
            S_WAIT_ACC:    w_next = !bus.scmdaccept ? S_WAIT_DONE : w_to ? S_ERR : S_WAIT_ACC;
            S_WAIT_DONE:   w_next = bus.scmdaccept ? S_NEXT : w_to ? S_ERR : S_WAIT_DONE;
            S_DELAY:       w_next = (r_dly < 32'd2) ? S_NEXT : S_DELAY;
            S_NEXT:        w_next = (r_ptr == {AW{1'b1}}) ? S_DONE : S_FETCH;
            // r_ack masks the request the host has not yet dropped after its ack
            S_DONE:        w_next = start ? S_FETCH : (host_req && !r_ack) ? S_H_ISSUE : S_DONE;
            S_H_ISSUE:     w_next = S_H_WAIT_ACC;
            S_H_WAIT_ACC:  w_next = !bus.scmdaccept ? S_H_WAIT_DONE : w_to ? S_ERR : S_H_WAIT_ACC;
            S_H_WAIT_DONE: w_next = bus.scmdaccept ? S_DONE : w_to ? S_ERR : S_H_WAIT_DONE;
            S_ERR:         w_next = start ? S_FETCH : S_ERR;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge sccb_clk or posedge sccb_reset) begin
        if (sccb_reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_entry <= '0;
            r_hrd   <= 1'b0;
            r_cap   <= 1'b0;
            r_ack   <= 1'b0;
            r_dly   <= '0;
            r_to    <= '0;
            r_mcmd  <= '0;
            r_maddr <= '0;
            r_mdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            r_to    <= (w_next == r_state && w_wait) ? r_to + 24'd1 : '0;
            r_ack   <= (r_state == S_H_WAIT_DONE) && (w_next == S_DONE);
            r_cap   <= (r_state == S_H_WAIT_DONE) && (r_cap || bus.sresp == 2'b01);
            if (w_next == S_FETCH)
                r_ptr <= (r_state == S_NEXT) ? r_ptr + AW'(1) : '0;
            if (r_state == S_DECODE) begin
                r_entry <= tbl_data;
                r_dly   <= 32'(tbl_data[7:0]) * 32'(DELAY_UNIT);
            end else if (r_state == S_DELAY)
                r_dly <= r_dly - 32'd1;
            if (r_state == S_DONE && w_next == S_H_ISSUE) begin
                r_entry <= {host_addr, host_wdata};
                r_hrd   <= host_rd;
            end
            // mcmd must drop as soon as the bridge takes the command, or it re-executes it
            if (r_state == S_ISSUE || r_state == S_H_ISSUE) begin
                r_mcmd  <= (r_state == S_H_ISSUE && r_hrd) ? 3'b010 : 3'b001;
                r_maddr <= {dev_id, r_entry[15:8]};
                r_mdata <= r_entry[7:0];
            end else if (w_next inside {S_WAIT_DONE, S_H_WAIT_DONE, S_ERR})
                r_mcmd <= '0;
            if (r_state == S_H_WAIT_DONE && r_hrd && !r_cap && bus.sresp == 2'b01)
                r_rdata <= bus.sdata;
        end
    end

    assign tbl_addr   = r_ptr;
    assign bus.mcmd   = r_mcmd;
    assign bus.maddr  = r_maddr;
    assign bus.mdata  = r_mdata;
    assign busy       = !(r_state inside {S_IDLE, S_DONE, S_ERR});
    assign done       = (r_state == S_DONE);
    assign error      = (r_state == S_ERR);
    assign host_ack   = r_ack;
    assign host_rdata = r_rdata;
endmodule

// File: tb/tb_sccb_init_seq.sv
// tb_sccb_init_seq: random init tables and host accesses against a list-walking reference model.
module tb_sccb_init_seq;
    localparam int          AW = 4;
    localparam int          N  = 16;
    localparam int          DU = 10;
    localparam logic [23:0] TO = 24'd100;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [6:0]    dev_id = '0;
    logic [AW-1:0] tbl_addr;
    logic [15:0]   tbl_data;
    logic          busy, done, error, host_ack;
    logic          host_req = 1'b0, host_rd = 1'b0;
    logic [7:0]    host_addr = '0, host_wdata = '0, host_rdata;
    int            checks = 0, failures = 0;

    sccb_bus_if bus();

    sccb_init_seq #(.AW(AW), .DELAY_UNIT(DU), .TIMEOUT(TO)) dut (
        .sccb_clk(clk), .sccb_reset(rst), .start(start), .dev_id(dev_id),
        .tbl_addr(tbl_addr), .tbl_data(tbl_data), .bus(bus),
        .busy(busy), .done(done), .error(error),
        .host_req(host_req), .host_rd(host_rd), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ack(host_ack), .host_rdata(host_rdata)
    );

    always #5 clk = ~clk;

    logic [15:0] rom [N];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    // bridge model: accepts when idle, busy 3..8 cycles, DVA two cycles before returning idle
    bit          dead = 1'b0;
    logic [7:0]  rd_val = 8'h76;
    int          br_cnt, stale, ack_cnt;
    bit          br_first, br_rd;
    logic [25:0] log_q[$];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.scmdaccept <= 1'b1;
            bus.sresp      <= 2'b00;
            bus.sdata      <= 8'h00;
            br_cnt         <= 0;
            br_first       <= 1'b0;
            br_rd          <= 1'b0;
        end else begin
            bus.sresp <= 2'b00;
            if (bus.scmdaccept) begin
                if (bus.mcmd != 3'b000 && !dead) begin
                    log_q.push_back({bus.mcmd, bus.maddr, bus.mdata});
                    bus.scmdaccept <= 1'b0;
                    br_cnt         <= $urandom_range(3, 8);
                    br_first       <= 1'b1;
                    br_rd          <= (bus.mcmd == 3'b010);
                end
            end else begin
                if (!br_first && bus.mcmd != 3'b000) stale <= stale + 1;
                br_first <= 1'b0;
                if (br_cnt == 2) begin
                    bus.sresp <= 2'b01;
                    bus.sdata <= br_rd ? rd_val : ~rd_val;
                end
                if (br_cnt == 0) bus.scmdaccept <= 1'b1;
                else br_cnt <= br_cnt - 1;
            end
        end
    end

    always @(negedge clk) if (host_ack) ack_cnt <= ack_cnt + 1;

    // reference: the writes the table implies, and where the walk stops
    logic [25:0] exp_q[$];
    int          exp_last;
    task automatic model_table(input logic [6:0] dev);
        exp_q.delete();
        exp_last = N - 1;
        for (int i = 0; i < N; i++) begin
            if (rom[i][15:8] == 8'hFF) begin
                exp_last = i;
                break;
            end
            if (rom[i][15:8] != 8'hFE) exp_q.push_back({3'b001, dev, rom[i]});
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_ack(input int limit, output bit seen);
        int c = 0;
        seen = 1'b0;
        while (!host_ack && c < limit) begin
            @(negedge clk);
            c++;
        end
        seen = host_ack;
    endtask

    task automatic fill_end;
        for (int i = 0; i < N; i++) rom[i] = 16'hFF00;
    endtask

    task automatic test_reset;
        logic [48:0] v;
        repeat (3) @(negedge clk);
        v = {bus.mcmd, bus.maddr, bus.mdata, tbl_addr, busy, done, error, host_ack, host_rdata};
        checks++;
        if (v !== '0) begin failures++; $display("FAIL reset_held: got %h exp 0", v); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        v = {bus.mcmd, bus.maddr, bus.mdata, tbl_addr, busy, done, error, host_ack, host_rdata};
        checks++;
        if (v !== '0) begin failures++; $display("FAIL reset_idle: got %h exp 0", v); end
    endtask

    task automatic test_basic;
        int cyc, s0;
        fill_end();
        rom[0] = 16'h1280;
        rom[1] = 16'h1101;
        dev_id = 7'h21;
        log_q.delete();
        s0 = stale;
        pulse_start();
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b exp 1", busy); end
        wait_done(500, cyc);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL basic_done: got %b exp 1 after %0d cycles", done, cyc); end
        checks++;
        if (log_q.size() != 2) begin failures++; $display("FAIL basic_count: got %0d exp 2", log_q.size()); end
        else begin
            checks++;
            if (log_q[0] !== {3'b001, 15'h2112, 8'h80}) begin failures++; $display("FAIL basic_w0: got %h exp %h", log_q[0], {3'b001, 15'h2112, 8'h80}); end
            checks++;
            if (log_q[1] !== {3'b001, 15'h2111, 8'h01}) begin failures++; $display("FAIL basic_w1: got %h exp %h", log_q[1], {3'b001, 15'h2111, 8'h01}); end
        end
        checks++;
        if (stale != s0) begin failures++; $display("FAIL basic_mcmd_drop: got %0d late cycles exp 0", stale - s0); end
        checks++;
        if (tbl_addr !== 4'd2) begin failures++; $display("FAIL basic_tbl_addr: got %0d exp 2", tbl_addr); end
        checks++;
        if ({busy, error} !== 2'b00) begin failures++; $display("FAIL basic_flags: got busy=%b error=%b exp 0 0", busy, error); end
    endtask

    task automatic test_random_tables;
        int cyc, r;
        for (int t = 0; t < 6; t++) begin
            dev_id = 7'($urandom);
            for (int i = 0; i < N; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) rom[i] = {8'hFE, 8'($urandom_range(0, 2))};
                else if (r == 1 && t != 5) rom[i] = {8'hFF, 8'($urandom)};
                else rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
            end
            model_table(dev_id);
            log_q.delete();
            pulse_start();
            wait_done(5000, cyc);
            checks++;
            if (done !== 1'b1) begin failures++; $display("FAIL rand_done[%0d]: got %b exp 1", t, done); end
            checks++;
            if (log_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_count[%0d]: got %0d exp %0d", t, log_q.size(), exp_q.size()); end
            else for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand_w[%0d][%0d]: got %h exp %h", t, i, log_q[i], exp_q[i]); end
            end
            checks++;
            if (tbl_addr !== AW'(exp_last)) begin failures++; $display("FAIL rand_tbl_addr[%0d]: got %0d exp %0d", t, tbl_addr, exp_last); end
        end
    endtask

    task automatic test_delay;
        int cyc;
        fill_end();
        rom[0] = 16'hFE03;
        log_q.delete();
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL delay_done: got %b exp 1", done); end
        checks++;
        if (cyc - 1 < 30 || cyc - 1 > 36) begin failures++; $display("FAIL delay_len: got %0d cycles after decode exp 30..36", cyc - 1); end
        rom[0] = 16'hFE00;
        pulse_start();
        wait_done(200, cyc);
        checks++;
        if (done !== 1'b1 || cyc > 6) begin failures++; $display("FAIL delay_zero: got done=%b after %0d cycles exp 1 within 6", done, cyc); end
        checks++;
        if (log_q.size() != 0) begin failures++; $display("FAIL delay_nocmd: got %0d commands exp 0", log_q.size()); end
    endtask

    task automatic test_timeout;
        int cyc;
        fill_end();
        rom[0] = 16'h1234;
        log_q.delete();
        dead = 1'b1;
        pulse_start();
        cyc = 0;
        while (!error && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc - 2 < 95 || cyc - 2 > 110) begin failures++; $display("FAIL to_time: got %0d cycles after issue exp 95..110", cyc - 2); end
        checks++;
        if ({error, busy, bus.mcmd} !== 5'b10000) begin failures++; $display("FAIL to_flags: got error=%b busy=%b mcmd=%0d exp 1 0 0", error, busy, bus.mcmd); end
        dead = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (error !== 1'b1) begin failures++; $display("FAIL to_sticky: got %b exp 1", error); end
        pulse_start();
        checks++;
        if ({error, busy} !== 2'b01) begin failures++; $display("FAIL to_restart: got error=%b busy=%b exp 0 1", error, busy); end
        wait_done(500, cyc);
        checks++;
        if (log_q.size() != 1 || done !== 1'b1) begin failures++; $display("FAIL to_recover: got %0d cmds done=%b exp 1 1", log_q.size(), done); end
        else begin
            checks++;
            if (log_q[0] !== {3'b001, dev_id, 16'h1234}) begin failures++; $display("FAIL to_cmd: got %h exp %h", log_q[0], {3'b001, dev_id, 16'h1234}); end
        end
    endtask

    task automatic test_host;
        bit seen;
        int a0;
        logic [7:0] got, wa, wd;
        dev_id = 7'h21;
        for (int k = 0; k < 2; k++) begin
            wa = (k == 0) ? 8'h0A : 8'($urandom);
            wd = 8'($urandom);
            log_q.delete();
            a0 = ack_cnt;
            host_rd = (k == 0);
            host_addr = wa;
            host_wdata = wd;
            host_req = 1'b1;
            wait_ack(200, seen);
            got = host_rdata;
            host_req = 1'b0;
            repeat (6) @(negedge clk);
            checks++;
            if (!seen) begin failures++; $display("FAIL host_ack_seen[%0d]: got 0 exp 1", k); end
            checks++;
            if (got !== 8'h76) begin failures++; $display("FAIL host_rdata[%0d]: got %h exp 76", k, got); end
            checks++;
            if (ack_cnt - a0 != 1) begin failures++; $display("FAIL host_ack_count[%0d]: got %0d exp 1", k, ack_cnt - a0); end
            checks++;
            if (log_q.size() != 1) begin failures++; $display("FAIL host_count[%0d]: got %0d exp 1", k, log_q.size()); end
            else if (k == 0) begin
                checks++;
                if (log_q[0][25:8] !== {3'b010, 15'h210A}) begin failures++; $display("FAIL host_read_cmd: got %h exp %h", log_q[0][25:8], {3'b010, 15'h210A}); end
            end else begin
                checks++;
                if (log_q[0] !== {3'b001, 7'h21, wa, wd}) begin failures++; $display("FAIL host_write_cmd: got %h exp %h", log_q[0], {3'b001, 7'h21, wa, wd}); end
            end
        end
        checks++;
        if ({done, busy} !== 2'b10) begin failures++; $display("FAIL host_state: got done=%b busy=%b exp 1 0", done, busy); end
    endtask

    task automatic test_host_held;
        int cyc, a0, n_at_done;
        bit seen;
        fill_end();
        for (int i = 0; i < 3; i++) rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
        model_table(dev_id);
        log_q.delete();
        a0 = ack_cnt;
        host_rd = 1'b0;
        host_addr = 8'h55;
        host_wdata = 8'($urandom);
        host_req = 1'b1;
        pulse_start();
        wait_done(1000, cyc);
        n_at_done = log_q.size();
        checks++;
        if (ack_cnt != a0 || done !== 1'b1) begin failures++; $display("FAIL held_early: got %0d acks done=%b exp 0 1", ack_cnt - a0, done); end
        checks++;
        if (n_at_done != 3) begin failures++; $display("FAIL held_init: got %0d writes at done exp 3", n_at_done); end
        wait_ack(200, seen);
        host_req = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (!seen || ack_cnt - a0 != 1) begin failures++; $display("FAIL held_ack: got %0d acks exp 1", ack_cnt - a0); end
        checks++;
        if (log_q.size() != 4) begin failures++; $display("FAIL held_count: got %0d exp 4", log_q.size()); end
        else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL held_w%0d: got %h exp %h", i, log_q[i], exp_q[i]); end
            end
            checks++;
            if (log_q[3] !== {3'b001, dev_id, 8'h55, host_wdata}) begin failures++; $display("FAIL held_host: got %h exp %h", log_q[3], {3'b001, dev_id, 8'h55, host_wdata}); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, c;
        logic [48:0] v;
        fill_end();
        for (int i = 0; i < 3; i++) rom[i] = {8'($urandom_range(0, 253)), 8'($urandom)};
        log_q.delete();
        pulse_start();
        c = 0;
        while (!(bus.scmdaccept === 1'b0 && bus.mcmd === 3'b000) && c < 100) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (c >= 100) begin failures++; $display("FAIL mid_reach_wait: got no bridge busy phase exp one within 100"); end
        #2 rst = 1'b1;
        #1 v = {bus.mcmd, bus.maddr, bus.mdata, tbl_addr, busy, done, error, host_ack, host_rdata};
        checks++;
        if (v !== '0) begin failures++; $display("FAIL mid_reset_outputs: got %h exp 0", v); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_table(dev_id);
        log_q.delete();
        pulse_start();
        wait_done(1000, cyc);
        checks++;
        if (log_q.size() != exp_q.size() || done !== 1'b1) begin failures++; $display("FAIL mid_replay_count: got %0d done=%b exp %0d 1", log_q.size(), done, exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin failures++; $display("FAIL mid_replay_w%0d: got %h exp %h", i, log_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        fill_end();
        test_reset();
        test_basic();
        test_random_tables();
        test_delay();
        test_timeout();
        test_host();
        test_host_held();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
